// File: rtl/spart_pkg.sv
// Shared types and constants for the SPART receive path.
//   rx_state_t  : receiver FSM states
//   PARITY_EVEN : parity-select value for even parity
//   PARITY_ODD  : parity-select value for odd parity
package spart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } rx_state_t;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/spart_fifo.sv
// Small synchronous FIFO for received SPART words.
//   clk, rst : clock and synchronous active-high reset (clears storage, pointers, count)
//   push     : write wdata; ignored when full unless a pop happens in the same cycle
//   pop      : drop the head entry; ignored when empty
//   wdata    : word to write
//   head     : current head entry, all zeros when empty
//   full     : DEPTH entries held
//   empty    : no entries held
module spart_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] CountFull = (PtrW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [PtrW:0]    count_q;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CountFull);
    assign do_pop  = pop && !empty;
    // A pop from a full FIFO frees the slot the simultaneous push needs.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/spart_rx.sv
// SPART serial receiver: 2-flop line synchroniser, 3-sample majority voter, frame FSM,
// receive FIFO and sticky error flags.
//   clk, rst   : clock and synchronous active-high reset
//   baud_en    : oversample tick (OVERSAMPLE per bit)
//   rxd        : asynchronous serial line, idles high
//   rd         : pop the FIFO head (ignored when empty)
//   err_clr    : clear all sticky error flags (a same-cycle set wins)
//   dout       : FIFO head word, zero when empty
//   rda        : FIFO non-empty
//   frame_err  : sticky, stop bit sampled 0
//   parity_err : sticky, parity mismatch
//   overrun    : sticky, word dropped because the FIFO was full
module spart_rx #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_en,
    input  logic                 rxd,
    input  logic                 rd,
    input  logic                 err_clr,
    output logic [DATA_BITS-1:0] dout,
    output logic                 rda,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    import spart_pkg::*;

    localparam int unsigned SW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_BITS + 1);
    localparam logic [SW-1:0] SMidM1 = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SMid   = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] SMidP1 = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] SLast  = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BLast  = BW'(DATA_BITS);
    localparam logic ParitySel = (PARITY_ODD != 0) ? spart_pkg::PARITY_ODD : PARITY_EVEN;

    rx_state_t            state_q;
    logic [1:0]           sync_q;
    logic [SW-1:0]        s_cnt_q;
    logic [BW-1:0]        bit_cnt_q;
    logic [1:0]           vote_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 pe_pending_q;
    logic                 frame_err_q;
    logic                 parity_err_q;
    logic                 overrun_q;

    logic rxd_s;
    logic decide;
    logic at_last;
    logic bit_val;
    logic push;
    logic fifo_full;
    logic fifo_empty;

    assign rxd_s   = sync_q[1];
    assign decide  = baud_en && (state_q != StIdle) && (s_cnt_q == SMidP1);
    assign at_last = (s_cnt_q == SLast);
    // Majority of the two stored samples and the live third sample.
    assign bit_val = (vote_q[0] & vote_q[1]) | (vote_q[0] & rxd_s) | (vote_q[1] & rxd_s);
    // Push at the stop-bit decision rather than the end of the stop bit.
    assign push    = decide && (state_q == StStop);

    spart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (rd),
        .wdata (shift_q),
        .head  (dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign rda        = !fifo_empty;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            sync_q       <= 2'b11;
            s_cnt_q      <= '0;
            bit_cnt_q    <= '0;
            vote_q       <= 2'b11;
            shift_q      <= '0;
            pe_pending_q <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], rxd};

            // Clear first so that a same-cycle set below takes priority.
            if (err_clr) begin
                frame_err_q  <= 1'b0;
                parity_err_q <= 1'b0;
                overrun_q    <= 1'b0;
            end
            if (push && !bit_val) begin
                frame_err_q <= 1'b1;
            end
            if (push && pe_pending_q) begin
                parity_err_q <= 1'b1;
            end
            // A simultaneous rd makes room, so only a push without rd into a full FIFO drops.
            if (push && fifo_full && !rd) begin
                overrun_q <= 1'b1;
            end

            if (baud_en) begin
                if (state_q != StIdle) begin
                    s_cnt_q <= at_last ? '0 : s_cnt_q + 1'b1;
                    if (s_cnt_q == SMidM1) vote_q[0] <= rxd_s;
                    if (s_cnt_q == SMid)   vote_q[1] <= rxd_s;
                end

                unique case (state_q)
                    StIdle: begin
                        if (!rxd_s) begin
                            state_q      <= StStart;
                            s_cnt_q      <= '0;
                            pe_pending_q <= 1'b0;
                        end
                    end
                    StStart: begin
                        if (decide && bit_val) begin
                            state_q <= StIdle;  // false start
                        end else if (at_last) begin
                            state_q   <= StData;
                            bit_cnt_q <= '0;
                        end
                    end
                    StData: begin
                        if (decide) begin
                            shift_q   <= {bit_val, shift_q[DATA_BITS-1:1]};
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                        if (at_last && (bit_cnt_q == BLast)) begin
                            state_q <= (PARITY_EN != 0) ? StParity : StStop;
                        end
                    end
                    StParity: begin
                        if (decide && (bit_val != ((^shift_q) ^ ParitySel))) begin
                            pe_pending_q <= 1'b1;
                        end
                        if (at_last) begin
                            state_q <= StStop;
                        end
                    end
                    StStop: begin
                        if (decide) begin
                            state_q <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spart_rx.sv
// Self-checking bench for spart_rx: an 8N1 instance (depth 4) and a 7-bit even-parity
// instance share clock, reset and baud tick. baud_en pulses every 4 clk, so one bit lasts
// 16 ticks = 64 clk. Frames are driven on the falling clock edge and outputs are sampled there.
module tb_spart_rx;

    localparam int BitClk = 64;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp_dout;
        logic       exp_fe;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_en = 1'b0;
    logic [1:0] baud_cnt = 2'd0;

    logic       rxd8 = 1'b1, rd8 = 1'b0, clr8 = 1'b0;
    logic [7:0] dout8;
    logic       rda8, fe8, pe8, ov8;

    logic       rxd7 = 1'b1, rd7 = 1'b0, clr7 = 1'b0;
    logic [6:0] dout7;
    logic       rda7, fe7, pe7, ov7;

    int total = 0;
    int bad   = 0;

    vec_t vecs [4];

    spart_rx #(
        .DATA_BITS(8), .OVERSAMPLE(16), .FIFO_DEPTH(4), .PARITY_EN(0), .PARITY_ODD(0)
    ) u_dut8 (
        .clk(clk), .rst(rst), .baud_en(baud_en), .rxd(rxd8), .rd(rd8), .err_clr(clr8),
        .dout(dout8), .rda(rda8), .frame_err(fe8), .parity_err(pe8), .overrun(ov8)
    );

    spart_rx #(
        .DATA_BITS(7), .OVERSAMPLE(16), .FIFO_DEPTH(4), .PARITY_EN(1), .PARITY_ODD(0)
    ) u_dut7 (
        .clk(clk), .rst(rst), .baud_en(baud_en), .rxd(rxd7), .rd(rd7), .err_clr(clr7),
        .dout(dout7), .rda(rda7), .frame_err(fe7), .parity_err(pe7), .overrun(ov7)
    );

    always #5 clk = ~clk;

    // Free-running baud generator, independent of rst like the real one.
    always @(posedge clk) begin
        baud_cnt <= baud_cnt + 2'd1;
        baud_en  <= (baud_cnt == 2'd3);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit use7, input logic b);
        if (use7) rxd7 = b;
        else      rxd8 = b;
    endtask

    // Sends nbits from frame LSB first, then idles high for two bit times.
    task automatic send_line(input bit use7, input logic [11:0] frame, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            drive(use7, frame[i]);
            repeat (BitClk) @(negedge clk);
        end
        drive(use7, 1'b1);
        repeat (2 * BitClk) @(negedge clk);
    endtask

    task automatic send8(input logic [7:0] d, input logic stop);
        send_line(1'b0, {2'b00, stop, d, 1'b0}, 10);
    endtask

    task automatic send7(input logic [6:0] d, input logic par);
        send_line(1'b1, {2'b00, 1'b1, par, d, 1'b0}, 10);
    endtask

    task automatic pulse_rd(input bit use7);
        if (use7) rd7 = 1'b1;
        else      rd8 = 1'b1;
        @(negedge clk);
        rd7 = 1'b0;
        rd8 = 1'b0;
    endtask

    task automatic pulse_clr(input bit use7);
        if (use7) clr7 = 1'b1;
        else      clr8 = 1'b1;
        @(negedge clk);
        clr7 = 1'b0;
        clr8 = 1'b0;
    endtask

    task automatic check_idle8(input string tag);
        check({tag, " dout8"}, {24'b0, dout8}, 32'h0);
        check({tag, " rda8"}, {31'b0, rda8}, 32'h0);
        check({tag, " frame_err8"}, {31'b0, fe8}, 32'h0);
        check({tag, " parity_err8"}, {31'b0, pe8}, 32'h0);
        check({tag, " overrun8"}, {31'b0, ov8}, 32'h0);
    endtask

    initial begin
        vecs[0] = '{data: 8'h55, stop: 1'b1, exp_dout: 8'h55, exp_fe: 1'b0};
        vecs[1] = '{data: 8'hA3, stop: 1'b0, exp_dout: 8'hA3, exp_fe: 1'b1};
        vecs[2] = '{data: 8'h0F, stop: 1'b1, exp_dout: 8'h0F, exp_fe: 1'b1};
        vecs[3] = '{data: 8'h80, stop: 1'b1, exp_dout: 8'h80, exp_fe: 1'b1};

        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle8("reset");
        check("reset rda7", {31'b0, rda7}, 32'h0);
        check("reset dout7", {25'b0, dout7}, 32'h0);

        // False start: line low for 4 ticks only.
        rxd8 = 1'b0;
        repeat (16) @(negedge clk);
        rxd8 = 1'b1;
        repeat (3 * BitClk) @(negedge clk);
        check_idle8("false start");

        // Table-driven 8N1 frames; frame_err stays set once the bad stop bit is seen.
        for (int v = 0; v < 4; v++) begin
            send8(vecs[v].data, vecs[v].stop);
            check($sformatf("vec%0d dout", v), {24'b0, dout8}, {24'b0, vecs[v].exp_dout});
            check($sformatf("vec%0d rda", v), {31'b0, rda8}, 32'h1);
            check($sformatf("vec%0d frame_err", v), {31'b0, fe8}, {31'b0, vecs[v].exp_fe});
            check($sformatf("vec%0d parity_err", v), {31'b0, pe8}, 32'h0);
            check($sformatf("vec%0d overrun", v), {31'b0, ov8}, 32'h0);
            pulse_rd(1'b0);
            check($sformatf("vec%0d rda after rd", v), {31'b0, rda8}, 32'h0);
            check($sformatf("vec%0d dout after rd", v), {24'b0, dout8}, 32'h0);
        end
        pulse_clr(1'b0);
        check("frame_err after clr", {31'b0, fe8}, 32'h0);

        // rd on an empty FIFO is ignored.
        pulse_rd(1'b0);
        check("empty rd rda", {31'b0, rda8}, 32'h0);

        // Overrun: five frames into a depth-4 FIFO.
        for (int i = 1; i <= 5; i++) begin
            send8(8'(i), 1'b1);
            check($sformatf("fill%0d overrun", i), {31'b0, ov8}, (i == 5) ? 32'h1 : 32'h0);
        end
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("pop%0d rda", i), {31'b0, rda8}, 32'h1);
            check($sformatf("pop%0d dout", i), {24'b0, dout8}, i);
            pulse_rd(1'b0);
        end
        check("after pops rda", {31'b0, rda8}, 32'h0);
        check("after pops dout", {24'b0, dout8}, 32'h0);
        check("overrun sticky", {31'b0, ov8}, 32'h1);
        pulse_clr(1'b0);
        check("overrun after clr", {31'b0, ov8}, 32'h0);

        // Reset in the middle of the 4th data bit while the FIFO and a flag are populated.
        send8(8'h77, 1'b0);
        check("pre-reset rda", {31'b0, rda8}, 32'h1);
        check("pre-reset frame_err", {31'b0, fe8}, 32'h1);
        rxd8 = 1'b0;
        repeat (BitClk) @(negedge clk);
        rxd8 = 1'b1;
        repeat (3 * BitClk + BitClk / 2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle8("mid-frame reset");
        repeat (2 * BitClk) @(negedge clk);
        send8(8'h3C, 1'b1);
        check("post-reset dout", {24'b0, dout8}, 32'h3C);
        check("post-reset rda", {31'b0, rda8}, 32'h1);
        check("post-reset frame_err", {31'b0, fe8}, 32'h0);
        check("post-reset overrun", {31'b0, ov8}, 32'h0);
        pulse_rd(1'b0);

        // 7-bit even parity: 0x41 has two ones, so parity bit 1 is wrong.
        send7(7'h41, 1'b1);
        check("7e1 dout bad par", {25'b0, dout7}, 32'h41);
        check("7e1 parity_err", {31'b0, pe7}, 32'h1);
        check("7e1 frame_err", {31'b0, fe7}, 32'h0);
        pulse_rd(1'b1);
        pulse_clr(1'b1);
        check("7e1 parity_err after clr", {31'b0, pe7}, 32'h0);
        // 0x07 has three ones, so parity bit 1 is correct.
        send7(7'h07, 1'b1);
        check("7e1 dout good par", {25'b0, dout7}, 32'h07);
        check("7e1 good parity_err", {31'b0, pe7}, 32'h0);
        pulse_rd(1'b1);
        check("7e1 rda after rd", {31'b0, rda7}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute guard so the bench always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, got running expected done");
        $fatal(1);
    end

endmodule
